// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode/branch inputs and stall/flush controls exchanged with the hazard unit.
interface hazard_ctrl_if;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_writes;
    logic [4:0]  id_rd;
    logic        id_is_branch;
    logic        br_resolve;
    logic        pc_hold;
    logic        ifid_hold;
    logic        ifid_flush;
    logic        idex_bubble;
    logic [15:0] stall_cycles;
    logic [15:0] branch_cnt;
    logic        err_spurious;
    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_writes, id_rd, id_is_branch, br_resolve,
        input  pc_hold, ifid_hold, ifid_flush, idex_bubble, stall_cycles, branch_cnt, err_spurious
    );
    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_writes, id_rd, id_is_branch, br_resolve,
        output pc_hold, ifid_hold, ifid_flush, idex_bubble, stall_cycles, branch_cnt, err_spurious
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: scoreboard-based RAW stall and branch-wait flush control for a 5-stage pipeline.
module hazard_ctrl #(
    parameter int SB_DEPTH = 3
) (
    input logic clk,
    input logic rst,
    hazard_ctrl_if.slave hz
);
    localparam logic [0:0] RUN = 1'b0;
    localparam logic [0:0] BR_WAIT = 1'b1;
    logic [0:0] state;
    logic [SB_DEPTH-1:0] sbValid;
    logic [4:0] sbRd [SB_DEPTH];
    logic [15:0] stallCycles;
    logic [15:0] branchCnt;
    logic errSpurious;
    logic raw;
    logic inRun;
    logic issueBranch;
    logic loadValid;
    always_comb begin
        raw = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++)
            raw = raw | (sbValid[i] & (((hz.id_rs != 5'd0) & (hz.id_rs == sbRd[i]))
                | (hz.id_uses_rt & (hz.id_rt != 5'd0) & (hz.id_rt == sbRd[i]))));
        raw = raw & hz.id_valid;
    end
    assign inRun = state == RUN;
    assign issueBranch = inRun & hz.id_valid & hz.id_is_branch & ~raw;
    assign loadValid = inRun & ~raw & hz.id_valid & hz.id_writes & (hz.id_rd != 5'd0);
    // In BR_WAIT the PC only moves on the resolve pulse, when it loads the target.
    assign hz.pc_hold = ~rst & (inRun ? raw : ~hz.br_resolve);
    assign hz.ifid_hold = ~rst & inRun & raw;
    assign hz.ifid_flush = ~rst & ~inRun;
    assign hz.idex_bubble = ~rst & (inRun ? raw : 1'b1);
    assign hz.stall_cycles = stallCycles;
    assign hz.branch_cnt = branchCnt;
    assign hz.err_spurious = errSpurious;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            sbValid <= '0;
            stallCycles <= '0;
            branchCnt <= '0;
            errSpurious <= 1'b0;
        end else begin
            state <= inRun ? (issueBranch ? BR_WAIT : RUN) : (hz.br_resolve ? RUN : BR_WAIT);
            sbValid <= {sbValid[SB_DEPTH-2:0], loadValid};
            if (hz.pc_hold && stallCycles != 16'hFFFF) stallCycles <= stallCycles + 16'd1;
            if (issueBranch && branchCnt != 16'hFFFF) branchCnt <= branchCnt + 16'd1;
            if (inRun && hz.br_resolve) errSpurious <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        sbRd[0] <= hz.id_rd;
        for (int i = 1; i < SB_DEPTH; i++) sbRd[i] <= sbRd[i-1];
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scenario-driven scoreboard bench for hazard_ctrl stall/flush outputs and counters.
module tb_hazard_ctrl;
    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] STALL = 4'b1101;
    localparam logic [3:0] WAIT = 4'b1011;
    localparam logic [3:0] RESOLVE = 4'b0011;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int nCompared = 0;
    int nMismatched = 0;
    logic [3:0] expQ [$];
    hazard_ctrl_if hz();
    hazard_ctrl #(.SB_DEPTH(3)) dut (.clk(clk), .rst(rst), .hz(hz));
    always #5 clk = ~clk;
    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step(input string tag, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic w, input logic [4:0] rd, input logic br,
                        input logic res, input logic [3:0] exp);
        hz.id_valid = v;
        hz.id_rs = rs;
        hz.id_rt = rt;
        hz.id_uses_rt = urt;
        hz.id_writes = w;
        hz.id_rd = rd;
        hz.id_is_branch = br;
        hz.br_resolve = res;
        expQ.push_back(exp);
        @(negedge clk);
        checkVal(tag, {hz.pc_hold, hz.ifid_hold, hz.ifid_flush, hz.idex_bubble}, expQ.pop_front());
        @(posedge clk);
        #1;
    endtask
    task automatic nop(input string tag, input logic [3:0] exp);
        step(tag, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, exp);
    endtask
    initial begin
        step("rst_out", 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, NONE);
        checkVal("rst_stall", hz.stall_cycles, 0);
        checkVal("rst_brcnt", hz.branch_cnt, 0);
        checkVal("rst_err", hz.err_spurious, 0);
        rst = 1'b0;
        step("w5", 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, NONE);
        for (int i = 0; i < 3; i++) step("r5_stall", 1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, STALL);
        step("r5_go", 1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, NONE);
        checkVal("stall_3", hz.stall_cycles, 3);
        step("w0", 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, NONE);
        step("r0", 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, NONE);
        step("w5b", 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, NONE);
        step("r7_8", 1'b1, 5'd7, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, NONE);
        for (int i = 0; i < 3; i++) nop("drain1", NONE);
        checkVal("stall_indep", hz.stall_cycles, 3);
        step("w9", 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, NONE);
        nop("n9a", NONE);
        nop("n9b", NONE);
        step("rt9_stall", 1'b1, 5'd1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, STALL);
        step("rt9_go", 1'b1, 5'd1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, NONE);
        checkVal("stall_wb", hz.stall_cycles, 4);
        step("w9b", 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, NONE);
        nop("n9c", NONE);
        nop("n9d", NONE);
        step("rt9_unused", 1'b1, 5'd1, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, NONE);
        for (int i = 0; i < 3; i++) nop("drain2", NONE);
        checkVal("stall_nort", hz.stall_cycles, 4);
        step("br_issue", 1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, NONE);
        step("brw_1", 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0, WAIT);
        step("brw_2", 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0, WAIT);
        step("brw_res", 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd12, 1'b0, 1'b1, RESOLVE);
        step("after_br", 1'b1, 5'd12, 5'd12, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, NONE);
        checkVal("brcnt_1", hz.branch_cnt, 1);
        checkVal("stall_br", hz.stall_cycles, 6);
        checkVal("err_clean", hz.err_spurious, 0);
        for (int i = 0; i < 3; i++) nop("drain3", NONE);
        step("w3", 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, NONE);
        for (int i = 0; i < 3; i++) step("brraw_stall", 1'b1, 5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, STALL);
        step("brraw_go", 1'b1, 5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, NONE);
        step("brraw_res", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, RESOLVE);
        checkVal("brcnt_2", hz.branch_cnt, 2);
        checkVal("stall_brraw", hz.stall_cycles, 9);
        step("spur", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, NONE);
        checkVal("err_set", hz.err_spurious, 1);
        nop("spur_n1", NONE);
        nop("spur_n2", NONE);
        checkVal("err_sticky", hz.err_spurious, 1);
        checkVal("stall_spur", hz.stall_cycles, 9);
        step("w20", 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd20, 1'b0, 1'b0, NONE);
        step("br_rst", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, NONE);
        step("brw_rst", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, WAIT);
        rst = 1'b1;
        step("rst_mid", 1'b1, 5'd20, 5'd0, 1'b0, 1'b1, 5'd21, 1'b1, 1'b1, NONE);
        rst = 1'b0;
        checkVal("rst2_stall", hz.stall_cycles, 0);
        checkVal("rst2_brcnt", hz.branch_cnt, 0);
        checkVal("rst2_err", hz.err_spurious, 0);
        step("rst2_run", 1'b1, 5'd20, 5'd21, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, NONE);
        step("sat_br", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, NONE);
        hz.id_is_branch = 1'b0;
        hz.id_valid = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        checkVal("stall_sat", hz.stall_cycles, 16'hFFFF);
        nop("sat_wait", WAIT);
        checkVal("stall_hold", hz.stall_cycles, 16'hFFFF);
        step("sat_res", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, RESOLVE);
        nop("sat_run", NONE);
        checkVal("brcnt_sat", hz.branch_cnt, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide parameter SB_DEPTH, default 3, number of in-flight writer stages tracked (EX, MEM, WB).
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port id_valid  input  1  decode-stage instruction valid.
REQ-005 SHALL provide port id_rs  input  5  decode source register 1 (always read).
REQ-006 SHALL provide port id_rt  input  5  decode source register 2.
REQ-007 SHALL provide port id_uses_rt  input  1  decode instruction reads id_rt.
REQ-008 SHALL provide port id_writes  input  1  decode instruction writes a register.
REQ-009 SHALL provide port id_rd  input  5  decode destination register (post RegDst mux).
REQ-010 SHALL provide port id_is_branch  input  1  decode instruction is a branch.
REQ-011 SHALL provide port br_resolve  input  1  one-cycle pulse from datapath: branch outcome applied to PC mux this cycle.
REQ-012 SHALL provide port pc_hold  output  1  PC keeps current value.
REQ-013 SHALL provide port ifid_hold  output  1  Stage1 register keeps contents.
REQ-014 SHALL provide port ifid_flush  output  1  Stage1 register loads NOP.
REQ-015 SHALL provide port idex_bubble  output  1  Stage2 register loads all-zero control (NOP).
REQ-016 SHALL provide port stall_cycles  output  16  count of cycles with pc_hold=1.
REQ-017 SHALL provide port branch_cnt  output  16  count of issued branches.
REQ-018 SHALL provide port err_spurious  output  1  sticky flag: br_resolve seen outside BR_WAIT.

Function
REQ-019 SHALL implement FSM states RUN and BR_WAIT.
REQ-020 SHALL keep a scoreboard shift register of SB_DEPTH entries {valid, rd}; entry 0 = EX, entry SB_DEPTH-1 = WB.
REQ-021 SHALL compute raw = id_valid & ((id_rs!=0 & id_rs matches any valid entry rd) | (id_uses_rt & id_rt!=0 & id_rt matches any valid entry rd)), combinationally, same cycle.
REQ-022 In RUN, SHALL drive pc_hold = ifid_hold = idex_bubble = raw, ifid_flush = 0.
REQ-023 Each cycle, SHALL shift scoreboard entries i -> i+1 (WB entry discarded).
REQ-024 In RUN without raw, SHALL load entry 0 with {id_valid & id_writes & id_rd!=0, id_rd}; with raw, or in BR_WAIT, SHALL load entry 0 invalid.
REQ-025 Register x0 SHALL never cause a hazard or occupy a valid entry.
REQ-026 In RUN, id_valid & id_is_branch & !raw SHALL issue the branch normally (no bubble), increment branch_cnt, and move to BR_WAIT next cycle.
REQ-027 A branch with raw SHALL stall like any instruction and not change state until its hazard clears.
REQ-028 In BR_WAIT, SHALL drive pc_hold=1, ifid_flush=1, idex_bubble=1, ifid_hold=0; id_* inputs ignored.
REQ-029 In BR_WAIT, br_resolve=1 SHALL drive pc_hold=0 that cycle (PC loads resolved target), keep ifid_flush=1 and idex_bubble=1, and return to RUN next cycle.
REQ-030 br_resolve=1 in RUN SHALL set err_spurious (sticky until reset) with no other effect.
REQ-031 stall_cycles SHALL increment on every cycle pc_hold=1 and saturate at 16'hFFFF; branch_cnt SHALL saturate at 16'hFFFF.
REQ-032 Latency: hazard outputs are combinational (0 cycles); state, scoreboard and counters update at the next rising edge.

Reset
REQ-033 While rst=1, SHALL force pc_hold, ifid_hold, ifid_flush and idex_bubble to 0.
REQ-034 On a rising edge with rst=1, SHALL enter RUN, clear all scoreboard valid bits, clear stall_cycles, branch_cnt and err_spurious; this takes priority over br_resolve and all id_* inputs, including mid-BR_WAIT.

Verification
REQ-035 Writer rd=5, then next cycle reader rs=5 -> pc_hold=ifid_hold=idex_bubble=1 for exactly 3 cycles, stall_cycles=3.
REQ-036 Writer rd=0, then reader rs=0 -> no stall; independent rs=7/rt=8 after writer rd=5 -> no stall.
REQ-037 Writer rd=9, two NOPs, reader with id_uses_rt=1, rt=9 -> exactly 1 stall cycle (WB match); with id_uses_rt=0 -> 0 stalls.
REQ-038 Branch issued, br_resolve after 2 cycles -> 3 cycles ifid_flush=1, pc_hold=1,1,0, RUN afterwards, branch_cnt=1.
REQ-039 br_resolve pulse in RUN -> err_spurious=1, held until rst; rst asserted in BR_WAIT -> RUN, scoreboard empty, counters 0 next cycle.
REQ-040 70000 consecutive hazard-stall cycles -> stall_cycles holds 16'hFFFF, no wrap.
